// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch (IF) and
// load/store (DM) requesters: round-robin on conflict, fixed issue/wait/respond sequence.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic       OWN_IF   = 1'b0;
   localparam logic       OWN_DM   = 1'b1;
   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              we_q, we_d;
   logic [3:0]        cnt_q, cnt_d;

   logic              grant_s;
   logic              pick_dm_s;
   logic              capture_s;

   logic              if_ready_q, if_ready_d;
   logic              dm_ready_q, dm_ready_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;

   // Grant decision and capture strobe; on conflict the side that did not go last wins.
   always_comb begin
      grant_s   = (state_q == S_IDLE) && (if_req || dm_req);
      pick_dm_s = dm_req && (!if_req || (last_owner_q == OWN_IF));
      capture_s = (state_q == S_WAIT) && (cnt_q == 4'd1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_IF;
         we_q         <= 1'b0;
         cnt_q        <= 4'd0;
         if_ready_q   <= 1'b0;
         dm_ready_q   <= 1'b0;
         if_rdata_q   <= {DATA_W{1'b0}};
         dm_rdata_q   <= {DATA_W{1'b0}};
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {ADDR_W{1'b0}};
         mem_wdata_q  <= {DATA_W{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         if_ready_q   <= if_ready_d;
         dm_ready_q   <= dm_ready_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (grant_s) begin
               state_d = S_ISSUE;
               owner_d = pick_dm_s ? OWN_DM : OWN_IF;
               we_d    = pick_dm_s && dm_we;
            end
         end
         S_ISSUE: begin
            cnt_d   = LAT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            last_owner_d = owner_q;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are computed one cycle ahead so the registered copies line up with ISSUE/DONE.
   always_comb begin
      mem_en_d    = grant_s;
      mem_we_d    = grant_s && pick_dm_s && dm_we;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (grant_s) begin
         mem_addr_d  = pick_dm_s ? dm_addr : if_addr;
         mem_wdata_d = pick_dm_s ? dm_wdata : {DATA_W{1'b0}};
      end
      if_ready_d = capture_s && (owner_q == OWN_IF);
      dm_ready_d = capture_s && (owner_q == OWN_DM);
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if (if_ready_d) begin
         if_rdata_d = mem_rdata;
      end
      if (dm_ready_d) begin
         dm_rdata_d = we_q ? {DATA_W{1'b0}} : mem_rdata;
      end
      busy_d = (state_d != S_IDLE);
   end

   assign if_ready  = if_ready_q;
   assign dm_ready  = dm_ready_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between the processor's instruction-fetch path (IF) and load/store path (DM). Sequences each access through a fixed issue/wait/respond FSM and returns a one-cycle ready pulse to the owning requester. Uses round-robin arbitration on conflict, so neither side starves. Sits between the processor datapath and the memory model used by the processor top level.

Parameters:
ADDR_W, 32, address width of both requesters and the memory.
DATA_W, 32, data width.
MEM_LAT, 2, memory read latency: cycles from mem_en to valid mem_rdata. Legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
if_req  in  1  fetch request level, held until if_ready.
if_addr  in  ADDR_W  fetch address, stable while if_req is high.
if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
if_rdata  out  DATA_W  fetched word, held until the next IF completion.
dm_req  in  1  data request level, held until dm_ready.
dm_we  in  1  1 = store, 0 = load.
dm_addr  in  ADDR_W  data address.
dm_wdata  in  DATA_W  store data.
dm_ready  out  1  one-cycle pulse: data access complete.
dm_rdata  out  DATA_W  load data; 0 after a store.
mem_en  out  1  memory access strobe, exactly one cycle per access.
mem_we  out  1  memory write enable, qualified by mem_en.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
busy  out  1  high in every non-IDLE state.

Behaviour:
- All outputs are registered. On reset, the following are 0: all outputs, if_rdata, dm_rdata, and the counter. State becomes IDLE. last_owner becomes IF, so the first conflict goes to DM.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req inputs are sampled only here.
  - Neither req: stay in IDLE.
  - Only one req: that side becomes owner.
  - Both reqs: owner = the side that is not last_owner.
  - When an owner is chosen: latch its addr, we, and wdata (IF forces we=0), then go to ISSUE.
- ISSUE: one cycle. mem_en=1; mem_we, mem_addr, mem_wdata driven from the latches. Load counter with MEM_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. The WAIT cycle in which the counter equals 1 is exactly MEM_LAT cycles after ISSUE. In that cycle, capture mem_rdata into the owner's rdata register (DM store captures 0), then go to DONE.
- DONE: owner's ready=1 for this cycle only. Update last_owner = owner. Go to IDLE.
- Timing: if the request is sampled in IDLE at cycle t:
  - mem_en is high at t+1.
  - ready is high at t+MEM_LAT+2.
  - Back-to-back throughput is one access per MEM_LAT+3 cycles.
- Requester rule: req must be low in the cycle after its ready pulse unless a new access is intended. A req still high in that IDLE cycle is a new request.
- The non-owner's req is ignored outside IDLE. It waits and is granted at the next IDLE if the owner does not re-request, or if it is next in round-robin order.
- mem_we is never 1 while mem_en is 0. mem_addr and mem_wdata hold their last values outside ISSUE.
- if_rdata and dm_rdata update only at their own capture cycle and are otherwise held.
- Reset mid-access: next cycle returns to IDLE with mem_en=0. No ready pulse is issued for the aborted access and rdata is cleared.
- MEM_LAT=1: WAIT lasts exactly one cycle.

Test Plan:
- MEM_LAT=2. if_req=1, if_addr=0x10 sampled in IDLE at cycle 0; mem_rdata=0x00500093 at cycle 3 -> mem_en=1 and mem_addr=0x10 at cycle 1 only; if_ready=1 at cycle 4 only; if_rdata=0x00500093; dm_ready stays 0.
- Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> at cycle 1, mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; dm_ready at cycle 4; dm_rdata=0.
- if_req and dm_req both high from reset release, both held, each re-requesting -> grant order DM, IF, DM, IF; ready pulses 5 cycles apart; mem_en count equals ready count.
- Load: dm_req=1, dm_we=0, addr=0x80, mem_rdata=0x1234 at capture -> dm_rdata=0x1234 and is held through a following IF access.
- reset=1 asserted during WAIT -> next cycle busy=0, mem_en=0, no ready pulse in the following 10 cycles with reqs low.
- MEM_LAT=1 rebuild with fetch at 0x0 -> mem_en at cycle 1, capture at cycle 2, if_ready at cycle 3.
